// File: rtl/cordic_vectoring_pkg.sv
// cordic_vectoring_pkg: package cordic_pkg with FSM states, arctangent table and gain constant
package cordic_pkg;
  typedef enum logic [1:0] {IDLE, ROTATE, COMP, DONE} state_t;
  localparam real PI = 3.14159265358979323846;
  localparam real K_GAIN = 0.6072529;
  function automatic real atan_rad(int i);
    real x, t, s;
    x = 1.0;
    for (int j = 0; j < i; j++) x = x / 2.0;
    t = x;
    s = 0.0;
    // Taylor series; atan(1) converges too slowly so it is taken exactly
    for (int k = 0; k < 64; k++) begin
      s = (k % 2 == 0) ? s + t / $itor(2 * k + 1) : s - t / $itor(2 * k + 1);
      t = t * x * x;
    end
    return i == 0 ? PI / 4.0 : s;
  endfunction
  function automatic int atan_lsb(int i, int aw);
    real s;
    s = atan_rad(i);
    for (int j = 1; j < aw; j++) s = s * 2.0;
    return $rtoi(s / PI + 0.5);
  endfunction
  function automatic int gain_k(int dw);
    real s;
    s = K_GAIN;
    for (int j = 0; j < dw; j++) s = s * 2.0;
    return $rtoi(s + 0.5);
  endfunction
endpackage

// File: rtl/cordic_vectoring_if.sv
// cordic_vectoring_if: valid/ready input pair and result channels of the vectoring CORDIC
interface cordic_vectoring_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic                 valid_i;
  logic                 ready_o;
  logic signed [DW-1:0] x_i;
  logic signed [DW-1:0] y_i;
  logic                 valid_o;
  logic                 ready_i;
  logic [DW+1:0]        mag_o;
  logic signed [AW-1:0] a_o;
  modport slave (input valid_i, x_i, y_i, ready_i, output ready_o, valid_o, mag_o, a_o);
  modport master (output valid_i, x_i, y_i, ready_i, input ready_o, valid_o, mag_o, a_o);
endinterface

// File: rtl/cordic_vectoring_rotator.sv
// vector_rotator: one combinational vectoring micro-rotation steering y toward zero
module vector_rotator #(
  parameter int W  = 18,
  parameter int AW = 16,
  parameter int SW = 4
) (
  input  logic signed [W-1:0]  x,
  input  logic signed [W-1:0]  y,
  input  logic signed [AW-1:0] a,
  input  logic [SW-1:0]        sh,
  input  logic signed [AW-1:0] atan,
  output logic signed [W-1:0]  xn,
  output logic signed [W-1:0]  yn,
  output logic signed [AW-1:0] an
);
  logic pos;
  logic signed [W-1:0] xs, ys;
  assign pos = !y[W-1];
  assign xs = x >>> sh;
  assign ys = y >>> sh;
  assign xn = pos ? x + ys : x - ys;
  assign yn = pos ? y - xs : y + xs;
  assign an = pos ? a + atan : a - atan;
endmodule

// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative vectoring CORDIC giving magnitude and atan2; CORDIC_VECTORING_GAIN_COMP_EN adds gain compensation
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int DW   = 16,
  parameter int AW   = 16,
  parameter int ITER = 14
) (
  input logic clk_i,
  input logic srst_i,
  cordic_vectoring_if.slave bus
);
  localparam int W  = DW + 2;
  localparam int IW = ITER > 1 ? $clog2(ITER) : 1;
  localparam logic signed [AW-1:0] QTR = AW'(1) << (AW - 2);
  state_t state, next;
  logic signed [W-1:0] x, y, xn, yn, xe, ye, x0, y0;
  logic signed [AW-1:0] a, an, a0;
  logic [IW-1:0] i;
  logic zero, last, xneg, yneg;
  logic [AW-1:0] atan_rom [2**IW];
  for (genvar k = 0; k < 2**IW; k++) begin : g_atan
    localparam logic [AW-1:0] AT = AW'(atan_lsb(k, AW));
    assign atan_rom[k] = AT;
  end
  // Quadrant pre-rotation brings the vector into the right half plane
  assign xneg = bus.x_i[DW-1];
  assign yneg = bus.y_i[DW-1];
  assign xe = {{2{bus.x_i[DW-1]}}, bus.x_i};
  assign ye = {{2{bus.y_i[DW-1]}}, bus.y_i};
  assign x0 = !xneg ? xe : yneg ? -ye : ye;
  assign y0 = !xneg ? ye : yneg ? xe : -xe;
  assign a0 = !xneg ? '0 : yneg ? -QTR : QTR;
  vector_rotator #(.W(W), .AW(AW), .SW(IW)) u_rot (
    .x(x), .y(y), .a(a), .sh(i), .atan(atan_rom[i]), .xn(xn), .yn(yn), .an(an)
  );
  assign last = i == IW'(ITER - 1);
`ifdef CORDIC_VECTORING_GAIN_COMP_EN
  localparam logic [DW-1:0] KG = DW'(gain_k(DW));
  localparam state_t POST = COMP;
  logic signed [W+DW:0] prod;
  logic signed [W-1:0] xc;
  assign prod = x * $signed({1'b0, KG});
  assign xc = prod[DW +: W];
`else
  localparam state_t POST = DONE;
`endif
  always_ff @(posedge clk_i) state <= srst_i ? IDLE : next;
  always_comb
    next = state == IDLE   ? (bus.valid_i ? ROTATE : IDLE) :
           state == ROTATE ? (last ? POST : ROTATE) :
           state == COMP   ? DONE :
                             (bus.ready_i ? IDLE : DONE);
  always_ff @(posedge clk_i)
    if (srst_i) begin
      x <= '0;
      y <= '0;
      a <= '0;
      i <= '0;
      zero <= 1'b0;
    end else if (state == IDLE && bus.valid_i) begin
      x <= x0;
      y <= y0;
      a <= a0;
      i <= '0;
      zero <= bus.x_i == '0 && bus.y_i == '0;
    end else if (state == ROTATE) begin
      x <= xn;
      y <= yn;
      a <= an;
      i <= i + 1'b1;
    end
`ifdef CORDIC_VECTORING_GAIN_COMP_EN
    else if (state == COMP) x <= xc;
`endif
  assign bus.ready_o = state == IDLE;
  assign bus.valid_o = state == DONE;
  // A zero vector has no defined phase; report it as all zeros
  assign bus.mag_o = bus.valid_o && !zero ? $unsigned(x) : '0;
  assign bus.a_o = bus.valid_o && !zero ? a : '0;
endmodule

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring: directed vector table plus backpressure and reset/zero sequences for cordic_vectoring
module tb_cordic_vectoring;
  localparam int DW = 16, AW = 16, ITER = 14;
`ifdef CORDIC_VECTORING_GAIN_COMP_EN
  localparam bit GC = 1'b1;
  localparam int LAT = ITER + 2;
`else
  localparam bit GC = 1'b0;
  localparam int LAT = ITER + 1;
`endif
  typedef struct {
    int x;
    int y;
    int a;
    int mr;
    int mc;
  } vec_t;
  logic clk = 1'b0;
  logic srst = 1'b1;
  int checks = 0, errors = 0;
  vec_t v [8];
  always #5 clk = ~clk;
  cordic_vectoring_if #(.DW(DW), .AW(AW)) bus ();
  cordic_vectoring #(.DW(DW), .AW(AW), .ITER(ITER)) dut (.clk_i(clk), .srst_i(srst), .bus(bus));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input int got, input int exp, input int tol);
    int d;
    d = got - exp;
    if (d < 0) d = -d;
    checks++;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d +/- %0d", name, got, exp, tol);
    end
  endtask
  task automatic check_ang(input string name, input int got, input int exp);
    int d;
    d = (got - exp) % 65536;
    if (d > 32767) d -= 65536;
    if (d < -32768) d += 65536;
    if (d < 0) d = -d;
    checks++;
    if (d > 3) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d +/- 3 (mod 2^16)", name, got, exp);
    end
  endtask
  task automatic send(input int x, input int y);
    int w;
    w = 0;
    while (!bus.ready_o && w < 200) begin
      step();
      w++;
    end
    if (w >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_ready: got ready_o=0 for 200 cycles, want 1");
    end
    bus.valid_i = 1'b1;
    bus.x_i = DW'(x);
    bus.y_i = DW'(y);
    step();
    bus.valid_i = 1'b0;
  endtask
  task automatic wait_valid(output int n);
    n = 1;
    while (!bus.valid_o && n < 200) begin
      step();
      n++;
    end
  endtask
  initial begin
    int n, cnt;
    v[0] = '{16384, 0, 0, 26981, 16384};
    v[1] = '{0, 16384, 16384, 26981, 16384};
    v[2] = '{-16384, 0, -32768, 26981, 16384};
    v[3] = '{10000, -10000, -8192, 23289, 14142};
    v[4] = '{-32768, -32768, -24576, 76312, 46341};
    v[5] = '{3000, 4000, 9672, 8234, 5000};
    v[6] = '{0, -16384, -16384, 26981, 16384};
    v[7] = '{-10000, 10000, 24576, 23289, 14142};
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    bus.x_i = '0;
    bus.y_i = '0;
    repeat (3) step();
    srst = 1'b0;
    step();
    check("rst_ready", int'(bus.ready_o), 1, 0);
    check("rst_valid", int'(bus.valid_o), 0, 0);
    check("rst_mag", int'(bus.mag_o), 0, 0);
    check("rst_angle", int'(bus.a_o), 0, 0);
    for (int k = 0; k < 8; k++) begin
      send(v[k].x, v[k].y);
      wait_valid(n);
      check($sformatf("vec%0d_latency", k), n, LAT, 0);
      check_ang($sformatf("vec%0d_angle", k), int'(bus.a_o), v[k].a);
      check($sformatf("vec%0d_mag", k), int'(bus.mag_o), GC ? v[k].mc : v[k].mr, 6);
      step();
      check($sformatf("vec%0d_one_cycle", k), int'(bus.valid_o), 0, 0);
      check($sformatf("vec%0d_ready_back", k), int'(bus.ready_o), 1, 0);
    end
    bus.ready_i = 1'b0;
    send(16384, 0);
    wait_valid(n);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("hold%0d_valid", k), int'(bus.valid_o), 1, 0);
      check($sformatf("hold%0d_ready", k), int'(bus.ready_o), 0, 0);
      check($sformatf("hold%0d_mag", k), int'(bus.mag_o), GC ? 16384 : 26981, 6);
      check_ang($sformatf("hold%0d_angle", k), int'(bus.a_o), 0);
      if (k == 3) begin
        bus.valid_i = 1'b1;
        bus.x_i = -16'sd16384;
        bus.y_i = '0;
      end
      step();
      bus.valid_i = 1'b0;
    end
    bus.ready_i = 1'b1;
    step();
    check("release_valid", int'(bus.valid_o), 0, 0);
    check("release_ready", int'(bus.ready_o), 1, 0);
    send(0, 16384);
    wait_valid(n);
    check("after_hold_latency", n, LAT, 0);
    check_ang("after_hold_angle", int'(bus.a_o), 16384);
    step();
    send(16384, 16384);
    repeat (4) step();
    srst = 1'b1;
    step();
    srst = 1'b0;
    check("abort_valid", int'(bus.valid_o), 0, 0);
    check("abort_ready", int'(bus.ready_o), 1, 0);
    cnt = 0;
    repeat (20) begin
      if (bus.valid_o) cnt++;
      step();
    end
    check("abort_no_partial", cnt, 0, 0);
    send(0, 0);
    wait_valid(n);
    check("zero_latency", n, LAT, 0);
    check("zero_mag", int'(bus.mag_o), 0, 0);
    check("zero_angle", int'(bus.a_o), 0, 0);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
